// File: rtl/pd_tx_arbiter.sv
// ---------------------------------------------------------------------------
// pd_tx_arbiter
//
// Purpose:
//   Shares the single PHY transmitter between two requesters. The rx block
//   asks for GoodCRC auto-responses, and the TCPM asks for buffered messages
//   by writing TRANSMIT. For a TCPM message the block also runs the retry
//   loop. It waits for the partner's GoodCRC, times out after CRC_TIMEOUT
//   cycles, and retransmits until the programmed attempts are used up. Each
//   outcome is reported as a one-cycle ALERT status pulse.
//
// Handshake protocol:
//   There is no valid/ready backpressure. Every request and completion input
//   is a one-cycle strobe, and the block samples it on the rising clk edge.
//   Every status output is a registered one-cycle strobe. The side-band
//   values (goodcrc_header, tx_retry_cnt) are sampled only in the cycle in
//   which their strobe is high.
//
// Ports:
//   clk                           system clock, rising edge
//   hard_reset                    asynchronous, active-high reset
//   goodcrc_req / goodcrc_header  rx: a received message needs a GoodCRC
//   tx_req / tx_retry_cnt         register file: TRANSMIT write strobe
//   phy_tx_done                   PHY finished the current frame
//   phy_rx_goodcrc                partner GoodCRC received for our message
//   phy_tx_start                  PHY begins a frame (pulse)
//   phy_tx_goodcrc                frame type, held for the whole frame
//   phy_tx_hdr                    GoodCRC header, held while phy_tx_goodcrc=1
//   GoodCRC_Transmission_Complete GoodCRC frame finished (pulse)
//   tx_success / tx_failed / tx_discarded  message outcome (pulses)
//   busy                          state is not IDLE
// ---------------------------------------------------------------------------
module pd_tx_arbiter #(
  parameter int CRC_TIMEOUT = 16,
  parameter int TMR_W       = 8
) (
  input  logic        clk,
  input  logic        hard_reset,
  input  logic        goodcrc_req,
  input  logic [15:0] goodcrc_header,
  input  logic        tx_req,
  input  logic [1:0]  tx_retry_cnt,
  input  logic        phy_tx_done,
  input  logic        phy_rx_goodcrc,
  output logic        phy_tx_start,
  output logic        phy_tx_goodcrc,
  output logic [15:0] phy_tx_hdr,
  output logic        GoodCRC_Transmission_Complete,
  output logic        tx_success,
  output logic        tx_failed,
  output logic        tx_discarded,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GCRC_TX  = 2'd1,
    ST_MSG_TX   = 2'd2,
    ST_CRC_WAIT = 2'd3
  } state_e;

  // The timeout fires in the cycle where the incremented timer reaches this
  // value. The retransmit start then lands exactly CRC_TIMEOUT cycles after
  // phy_tx_done.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CRC_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic [2:0]       att_q, att_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [TMR_W-1:0] tmr_inc;
  logic [15:0]      hdr_q, hdr_d;
  logic             start_q, start_d;
  logic             gcrc_q, gcrc_d;
  logic             gdone_q, gdone_d;
  logic             succ_q, succ_d;
  logic             fail_q, fail_d;
  logic             disc_q, disc_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    // A TRANSMIT write is remembered in every state. The IDLE branch below
    // clears it again when the same write launches the message at once.
    pend_d  = pend_q | tx_req;
    att_d   = att_q;
    tmr_d   = '0;
    tmr_inc = tmr_q + TMR_W'(1);
    hdr_d   = hdr_q;
    start_d = 1'b0;
    gdone_d = 1'b0;
    succ_d  = 1'b0;
    fail_d  = 1'b0;
    disc_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (goodcrc_req) begin
          state_d = ST_GCRC_TX;
          hdr_d   = goodcrc_header;
          start_d = 1'b1;
        end else if (pend_q || tx_req) begin
          state_d = ST_MSG_TX;
          pend_d  = 1'b0;
          start_d = 1'b1;
        end
      end

      ST_GCRC_TX: begin
        if (phy_tx_done) begin
          gdone_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_MSG_TX: begin
        if (phy_tx_done) begin
          // Saturate the count. A message queued behind a discard may have
          // had its attempts cleared, and it must not wrap to 7 retries.
          att_d   = (att_q != 3'd0) ? (att_q - 3'd1) : 3'd0;
          state_d = ST_CRC_WAIT;
        end else if (goodcrc_req) begin
          disc_d  = 1'b1;
          att_d   = 3'd0;
          hdr_d   = goodcrc_header;
          start_d = 1'b1;
          state_d = ST_GCRC_TX;
        end
      end

      ST_CRC_WAIT: begin
        tmr_d = tmr_inc;
        if (goodcrc_req) begin
          disc_d  = 1'b1;
          att_d   = 3'd0;
          hdr_d   = goodcrc_header;
          start_d = 1'b1;
          state_d = ST_GCRC_TX;
        end else if (phy_rx_goodcrc) begin
          succ_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (tmr_inc == TMR_LAST) begin
          if (att_q != 3'd0) begin
            start_d = 1'b1;
            state_d = ST_MSG_TX;
          end else begin
            fail_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A TRANSMIT write always reloads the attempt budget. This wins over a
    // decrement or a discard in the same cycle because it belongs to the
    // new message.
    if (tx_req) begin
      att_d = {1'b0, tx_retry_cnt} + 3'd1;
    end

    gcrc_d = (state_d == ST_GCRC_TX);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      att_q   <= 3'd0;
      tmr_q   <= '0;
      hdr_q   <= 16'h0000;
      start_q <= 1'b0;
      gcrc_q  <= 1'b0;
      gdone_q <= 1'b0;
      succ_q  <= 1'b0;
      fail_q  <= 1'b0;
      disc_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      att_q   <= att_d;
      tmr_q   <= tmr_d;
      hdr_q   <= hdr_d;
      start_q <= start_d;
      gcrc_q  <= gcrc_d;
      gdone_q <= gdone_d;
      succ_q  <= succ_d;
      fail_q  <= fail_d;
      disc_q  <= disc_d;
      busy_q  <= busy_d;
    end
  end

  assign phy_tx_start                  = start_q;
  assign phy_tx_goodcrc                = gcrc_q;
  assign phy_tx_hdr                    = hdr_q;
  assign GoodCRC_Transmission_Complete = gdone_q;
  assign tx_success                    = succ_q;
  assign tx_failed                     = fail_q;
  assign tx_discarded                  = disc_q;
  assign busy                          = busy_q;

endmodule

// File: tb/tb_pd_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pd_tx_arbiter
//
// Directed scenarios are followed by a randomized phase. Every cycle, every
// DUT output is compared with a behavioural model of the transmitter. The
// model tracks which frame is on the wire, whether an ack is awaited, a
// countdown to the ack deadline, the attempts left and a queued-message flag.
// Directed scenarios add spec-derived constant checks for latency and pulse
// counts.
// ---------------------------------------------------------------------------
module tb_pd_tx_arbiter;

  localparam int CRC_TIMEOUT = 16;
  localparam int TMR_W       = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        hard_reset;
  logic        goodcrc_req;
  logic [15:0] goodcrc_header;
  logic        tx_req;
  logic [1:0]  tx_retry_cnt;
  logic        phy_tx_done;
  logic        phy_rx_goodcrc;
  logic        phy_tx_start;
  logic        phy_tx_goodcrc;
  logic [15:0] phy_tx_hdr;
  logic        gcrc_complete;
  logic        tx_success;
  logic        tx_failed;
  logic        tx_discarded;
  logic        busy;

  pd_tx_arbiter #(.CRC_TIMEOUT(CRC_TIMEOUT), .TMR_W(TMR_W)) dut (
    .clk                           (clk),
    .hard_reset                    (hard_reset),
    .goodcrc_req                   (goodcrc_req),
    .goodcrc_header                (goodcrc_header),
    .tx_req                        (tx_req),
    .tx_retry_cnt                  (tx_retry_cnt),
    .phy_tx_done                   (phy_tx_done),
    .phy_rx_goodcrc                (phy_rx_goodcrc),
    .phy_tx_start                  (phy_tx_start),
    .phy_tx_goodcrc                (phy_tx_goodcrc),
    .phy_tx_hdr                    (phy_tx_hdr),
    .GoodCRC_Transmission_Complete (gcrc_complete),
    .tx_success                    (tx_success),
    .tx_failed                     (tx_failed),
    .tx_discarded                  (tx_discarded),
    .busy                          (busy)
  );

  int checks = 0;
  int errors = 0;

  // Observed pulse counters, used for the directed constant checks.
  int n_start, n_succ, n_fail, n_disc, n_gdone;

  // ---------------- behavioural model ----------------
  bit          m_gcrc_on;   // GoodCRC frame on the wire
  bit          m_msg_on;    // TCPM message frame on the wire
  bit          m_wait_on;   // awaiting the partner's GoodCRC
  int          m_wait_left; // cycles left before the ack deadline
  int          m_tries;     // attempts left for the current message
  bit          m_queued;    // a TRANSMIT write is waiting
  logic [15:0] m_hdr;
  bit          e_start, e_gdone, e_succ, e_fail, e_disc;

  task automatic model_reset();
    m_gcrc_on = 0; m_msg_on = 0; m_wait_on = 0; m_wait_left = 0;
    m_tries = 0; m_queued = 0; m_hdr = 16'h0000;
    e_start = 0; e_gdone = 0; e_succ = 0; e_fail = 0; e_disc = 0;
  endtask

  task automatic model_begin_gcrc(input logic [15:0] h);
    m_gcrc_on = 1; m_hdr = h; e_start = 1;
  endtask

  // Applies the inputs that were present at this clock edge.
  task automatic model_step();
    bit idle;
    e_start = 0; e_gdone = 0; e_succ = 0; e_fail = 0; e_disc = 0;
    idle = !(m_gcrc_on || m_msg_on || m_wait_on);
    if (idle) begin
      if (goodcrc_req) begin
        model_begin_gcrc(goodcrc_header);
        if (tx_req) m_queued = 1;
      end else if (m_queued || tx_req) begin
        m_msg_on = 1; e_start = 1; m_queued = 0;
      end
    end else if (m_gcrc_on) begin
      if (phy_tx_done) begin m_gcrc_on = 0; e_gdone = 1; end
      if (tx_req) m_queued = 1;
    end else if (m_msg_on) begin
      if (phy_tx_done) begin
        m_tries = (m_tries > 0) ? m_tries - 1 : 0;
        m_msg_on = 0; m_wait_on = 1; m_wait_left = CRC_TIMEOUT - 1;
      end else if (goodcrc_req) begin
        e_disc = 1; m_tries = 0; m_msg_on = 0;
        model_begin_gcrc(goodcrc_header);
      end
      if (tx_req) m_queued = 1;
    end else begin
      if (goodcrc_req) begin
        e_disc = 1; m_tries = 0; m_wait_on = 0;
        model_begin_gcrc(goodcrc_header);
      end else if (phy_rx_goodcrc) begin
        e_succ = 1; m_wait_on = 0;
      end else begin
        m_wait_left = m_wait_left - 1;
        if (m_wait_left == 0) begin
          m_wait_on = 0;
          if (m_tries != 0) begin m_msg_on = 1; e_start = 1; end
          else e_fail = 1;
        end
      end
      if (tx_req) m_queued = 1;
    end
    if (tx_req) m_tries = int'(tx_retry_cnt) + 1;
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("phy_tx_start", 16'(phy_tx_start), 16'(e_start));
    chk("phy_tx_goodcrc", 16'(phy_tx_goodcrc), 16'(m_gcrc_on));
    chk("phy_tx_hdr", phy_tx_hdr, m_hdr);
    chk("gcrc_complete", 16'(gcrc_complete), 16'(e_gdone));
    chk("tx_success", 16'(tx_success), 16'(e_succ));
    chk("tx_failed", 16'(tx_failed), 16'(e_fail));
    chk("tx_discarded", 16'(tx_discarded), 16'(e_disc));
    chk("busy", 16'(busy), 16'(m_gcrc_on || m_msg_on || m_wait_on));
    chk("status_exclusive",
        16'((int'(tx_success) + int'(tx_failed) + int'(tx_discarded)) > 1), 16'd0);
  endtask

  task automatic clear_pulses();
    goodcrc_req = 0; tx_req = 0; phy_tx_done = 0; phy_rx_goodcrc = 0;
  endtask

  task automatic clear_counts();
    n_start = 0; n_succ = 0; n_fail = 0; n_disc = 0; n_gdone = 0;
  endtask

  // One clock: the DUT and the model consume the current inputs, the outputs
  // are compared 1 time unit after the edge, and the pulse inputs drop.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    if (phy_tx_start)  n_start++;
    if (tx_success)    n_succ++;
    if (tx_failed)     n_fail++;
    if (tx_discarded)  n_disc++;
    if (gcrc_complete) n_gdone++;
    clear_pulses();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n;
    hard_reset = 1; goodcrc_header = 16'h0000; tx_retry_cnt = 2'd0;
    clear_pulses();
    model_reset();
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("reset_hdr", phy_tx_hdr, 16'h0000);
    hard_reset = 0;
    ticks(3);

    // GoodCRC only: request in cycle 10, done in cycle 20.
    clear_counts();
    goodcrc_req = 1; goodcrc_header = 16'h0161;
    tick();                                 // cycle 11
    chk("gc_start_c11", 16'(phy_tx_start), 16'd1);
    chk("gc_type_c11", 16'(phy_tx_goodcrc), 16'd1);
    chk("gc_hdr_c11", phy_tx_hdr, 16'h0161);
    ticks(9);                               // cycle 20
    chk("gc_type_c20", 16'(phy_tx_goodcrc), 16'd1);
    chk("gc_hdr_c20", phy_tx_hdr, 16'h0161);
    phy_tx_done = 1;
    tick();                                 // cycle 21
    chk("gc_complete_c21", 16'(gcrc_complete), 16'd1);
    chk("gc_busy_c21", 16'(busy), 16'd0);
    chk("gc_one_start", 16'(n_start), 16'd1);
    ticks(3);

    // Message acknowledged on the first attempt.
    clear_counts();
    tx_req = 1; tx_retry_cnt = 2'd2;
    tick();
    chk("ack_start", 16'(phy_tx_start), 16'd1);
    chk("ack_type", 16'(phy_tx_goodcrc), 16'd0);
    ticks(7);
    phy_tx_done = 1;
    tick();
    ticks(4);
    phy_rx_goodcrc = 1;
    tick();
    chk("ack_success", 16'(tx_success), 16'd1);
    ticks(20);
    chk("ack_starts", 16'(n_start), 16'd1);
    chk("ack_succ_count", 16'(n_succ), 16'd1);
    chk("ack_no_fail", 16'(n_fail), 16'd0);

    // Retries exhausted: 3 attempts, each retry CRC_TIMEOUT cycles after done.
    clear_counts();
    tx_req = 1; tx_retry_cnt = 2'd2;
    tick();
    for (int f = 0; f < 3; f++) begin
      ticks(3);
      phy_tx_done = 1;
      tick();
      n = 1;
      if (f < 2) begin
        while (!phy_tx_start && n < 64) begin tick(); n++; end
        chk("retry_gap", 16'(n), 16'(CRC_TIMEOUT));
      end else begin
        while (!tx_failed && n < 64) begin tick(); n++; end
        chk("fail_gap", 16'(n), 16'(CRC_TIMEOUT));
      end
    end
    chk("fail_busy", 16'(busy), 16'd0);
    chk("fail_starts", 16'(n_start), 16'd3);
    chk("fail_count", 16'(n_fail), 16'd1);
    chk("fail_no_succ", 16'(n_succ), 16'd0);
    ticks(3);

    // Simultaneous GoodCRC and TRANSMIT requests.
    goodcrc_req = 1; goodcrc_header = 16'h0041; tx_req = 1; tx_retry_cnt = 2'd0;
    tick();
    chk("sim_first_is_gcrc", 16'(phy_tx_goodcrc), 16'd1);
    chk("sim_first_start", 16'(phy_tx_start), 16'd1);
    ticks(3);
    phy_tx_done = 1;
    tick();
    chk("sim_gc_complete", 16'(gcrc_complete), 16'd1);
    chk("sim_no_early_start", 16'(phy_tx_start), 16'd0);
    tick();
    chk("sim_msg_start", 16'(phy_tx_start), 16'd1);
    chk("sim_msg_type", 16'(phy_tx_goodcrc), 16'd0);
    ticks(2);
    phy_tx_done = 1;
    tick();
    tick();
    phy_rx_goodcrc = 1;
    tick();
    chk("sim_msg_success", 16'(tx_success), 16'd1);
    ticks(3);

    // Discard: GoodCRC request while awaiting the partner's ack.
    clear_counts();
    tx_req = 1; tx_retry_cnt = 2'd1;
    tick();
    ticks(2);
    phy_tx_done = 1;
    tick();
    ticks(3);
    goodcrc_req = 1; goodcrc_header = 16'h1234;
    tick();
    chk("disc_pulse", 16'(tx_discarded), 16'd1);
    chk("disc_gcrc_start", 16'(phy_tx_start), 16'd1);
    chk("disc_gcrc_type", 16'(phy_tx_goodcrc), 16'd1);
    chk("disc_hdr", phy_tx_hdr, 16'h1234);
    ticks(2);
    phy_tx_done = 1;
    tick();
    ticks(40);
    chk("disc_no_succ", 16'(n_succ), 16'd0);
    chk("disc_no_fail", 16'(n_fail), 16'd0);
    chk("disc_count", 16'(n_disc), 16'd1);

    // Asynchronous hard reset in the middle of a message frame.
    tx_req = 1; tx_retry_cnt = 2'd3;
    tick();
    tick();
    hard_reset = 1;
    #1;
    model_reset();
    check_outputs();
    chk("rst_async_busy", 16'(busy), 16'd0);
    @(posedge clk);
    #1;
    check_outputs();
    hard_reset = 0;
    phy_rx_goodcrc = 1;
    tick();
    chk("rst_no_success", 16'(tx_success), 16'd0);
    ticks(3);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      goodcrc_req    = ($urandom_range(0, 30) == 0);
      goodcrc_header = 16'($urandom);
      tx_req         = ($urandom_range(0, 25) == 0);
      tx_retry_cnt   = 2'($urandom_range(0, 3));
      if (m_gcrc_on || m_msg_on) phy_tx_done = ($urandom_range(0, 5) == 0);
      else                       phy_tx_done = ($urandom_range(0, 40) == 0);
      if (m_wait_on) phy_rx_goodcrc = ($urandom_range(0, 12) == 0);
      else           phy_rx_goodcrc = ($urandom_range(0, 40) == 0);
      tick();
    end
    ticks(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
